// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scan driver with tear-free
// frame-boundary commit, blink, LZ blanking and dead time.
module seg_scan_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 25000,
  parameter int DEADTIME     = 64,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  input  logic                    update_valid,
  output logic                    update_pending,
  output logic                    frame_tick,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg
);

  localparam int N  = NUM_DIGITS;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]  presc;
  logic [IW-1:0]  idx;
  logic [FW-1:0]  fcnt;
  logic           blink_ph;

  logic [4*N-1:0] act_d, stg_d;
  logic [N-1:0]   act_dp, stg_dp;
  logic [N-1:0]   act_bm, stg_bm;
  logic           act_lz, stg_lz;

  logic           presc_tc;
  logic           wrap;
  logic [N-1:0]   lz_blank;
  logic           run;
  logic [3:0]     cur_d;
  logic           cur_dp, cur_bm, cur_lz;
  logic           blank;
  logic           dp_eff;
  logic [N-1:0]   an_nxt;
  logic [7:0]     seg_nxt;

  function automatic logic [6:0] hex7(
    input logic [3:0] v
  );
    unique case (v)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Slot end and frame wrap detection
  always_comb begin
    presc_tc = (presc == PW'(REFRESH_DIV - 1));
    wrap     = presc_tc && (idx == IW'(N - 1));
  end

  // Prescaler, scan index, frame tick and blink phase
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      fcnt       <= '0;
      blink_ph   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (presc_tc) begin
        presc <= '0;
        if (idx == IW'(N - 1)) idx <= '0;
        else                   idx <= idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      if (wrap) begin
        if (fcnt == FW'(BLINK_FRAMES - 1)) begin
          fcnt     <= '0;
          blink_ph <= ~blink_ph;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  // Staging and frame-boundary commit; a strobe on
  // the wrap cycle commits directly
  always_ff @(posedge clk) begin
    if (rst) begin
      act_d          <= '0;
      act_dp         <= '0;
      act_bm         <= '0;
      act_lz         <= 1'b0;
      stg_d          <= '0;
      stg_dp         <= '0;
      stg_bm         <= '0;
      stg_lz         <= 1'b0;
      update_pending <= 1'b0;
    end else if (wrap) begin
      if (update_valid) begin
        act_d  <= digits;
        act_dp <= dp;
        act_bm <= blink_mask;
        act_lz <= lz_en;
      end else if (update_pending) begin
        act_d  <= stg_d;
        act_dp <= stg_dp;
        act_bm <= stg_bm;
        act_lz <= stg_lz;
      end
      update_pending <= 1'b0;
    end else if (update_valid) begin
      stg_d          <= digits;
      stg_dp         <= dp;
      stg_bm         <= blink_mask;
      stg_lz         <= lz_en;
      update_pending <= 1'b1;
    end
  end

  // Current digit selection, blanking and decode
  always_comb begin
    run      = 1'b1;
    lz_blank = '0;
    cur_d    = '0;
    cur_dp   = 1'b0;
    cur_bm   = 1'b0;
    cur_lz   = 1'b0;
    an_nxt   = '1;
    for (int i = N - 1; i >= 0; i--) begin
      run = run & (act_d[4*i +: 4] == 4'h0);
      lz_blank[i] = act_lz & run & (i != 0);
    end
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        cur_d  = act_d[4*i +: 4];
        cur_dp = act_dp[i];
        cur_bm = act_bm[i];
        cur_lz = lz_blank[i];
        if (presc >= PW'(DEADTIME))
          an_nxt[i] = 1'b0;
      end
    end
    blank   = cur_lz | (cur_bm & blink_ph);
    dp_eff  = cur_dp & ~blank;
    seg_nxt = {~dp_eff,
               blank ? 7'h7F : hex7(cur_d)};
  end

  // Registered pin drivers
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= '1;
      seg <= 8'hFF;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: directed literal checks
// plus random traffic against a time-based model.
module tb_seg_scan_display;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int DT = 1;
  localparam int BF = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  digits;
  logic [3:0]   dp;
  logic [3:0]   blink_mask;
  logic         lz_en;
  logic         update_valid;
  logic         update_pending;
  logic         frame_tick;
  logic [3:0]   an;
  logic [7:0]   seg;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_display #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .DEADTIME    (DT),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .digits        (digits),
    .dp            (dp),
    .blink_mask    (blink_mask),
    .lz_en         (lz_en),
    .update_valid  (update_valid),
    .update_pending(update_pending),
    .frame_tick    (frame_tick),
    .an            (an),
    .seg           (seg)
  );

  always #5 clk = ~clk;

  // model: display is a function of cycles since reset
  int          t;
  bit          m_valid = 0;
  logic [15:0] m_d, s_d;
  logic [3:0]  m_dp, s_dp, m_bm, s_bm;
  logic        m_lz, s_lz, m_pend;
  logic [3:0]  e_an;
  logic [7:0]  e_seg;
  logic        e_tick, e_pend;

  always @(posedge clk) begin
    int pr, ix, fr, ph, dv;
    logic [15:0] hi;
    bit lzb, bb;
    if (rst) begin
      t = 0; m_valid = 1;
      m_d = '0; m_dp = '0; m_bm = '0; m_lz = 0;
      s_d = '0; s_dp = '0; s_bm = '0; s_lz = 0;
      m_pend = 0;
      e_an = 4'hF; e_seg = 8'hFF;
      e_tick = 0; e_pend = 0;
    end else if (m_valid) begin
      pr = t % RD;
      ix = (t / RD) % N;
      fr = t / (RD * N);
      ph = (fr / BF) % 2;
      e_an = (pr < DT) ? 4'hF : ~(4'b1 << ix);
      hi = m_d >> (4 * ix);
      dv = int'(hi & 16'hF);
      lzb = m_lz && ix > 0 && hi == 16'h0;
      bb = m_bm[ix] && ph == 1;
      e_seg = (lzb || bb) ? 8'hFF :
              {~m_dp[ix], HEX[dv]};
      e_tick = (pr == RD - 1) && (ix == N - 1);
      if (e_tick) begin
        if (update_valid) begin
          m_d = digits; m_dp = dp;
          m_bm = blink_mask; m_lz = lz_en;
        end else if (m_pend) begin
          m_d = s_d; m_dp = s_dp;
          m_bm = s_bm; m_lz = s_lz;
        end
        m_pend = 0;
      end else if (update_valid) begin
        s_d = digits; s_dp = dp;
        s_bm = blink_mask; s_lz = lz_en;
        m_pend = 1;
      end
      e_pend = m_pend;
      t++;
    end
  end

  task automatic chk(input string nm,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("an",   {4'h0, an},    {4'h0, e_an});
      chk("seg",  seg,           e_seg);
      chk("pend", {7'h0, update_pending},
                  {7'h0, e_pend});
      chk("tick", {7'h0, frame_tick},
                  {7'h0, e_tick});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_tick();
    int i = 0;
    bit hit = 0;
    while (i < 64 && !hit) begin
      step();
      hit = frame_tick;
      i++;
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL wait_tick: no frame_tick in 64");
    end
  endtask

  // called at a tick edge; walks one whole frame
  task automatic scan_chk(input logic [7:0] s0,
                          input logic [7:0] s1,
                          input logic [7:0] s2,
                          input logic [7:0] s3);
    logic [7:0] sv [4];
    logic [3:0] av [4];
    sv = '{s0, s1, s2, s3};
    av = '{4'hE, 4'hD, 4'hB, 4'h7};
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("scan_an", {4'h0, an},
          (k % 4 == 1) ? 8'h0F :
                         {4'h0, av[(k-1)/4]});
      chk("scan_seg", seg, sv[(k-1)/4]);
    end
  endtask

  initial begin
    bit lit [8];
    bit prev_p;
    int nlit;
    rst = 1; update_valid = 0; digits = '0;
    dp = '0; blink_mask = '0; lz_en = 0;
    repeat (3) step();
    chk("rst_an",   {4'h0, an}, 8'h0F);
    chk("rst_seg",  seg, 8'hFF);
    chk("rst_pend", {7'h0, update_pending}, 8'h0);
    rst = 0;
    step();
    chk("rel1_an", {4'h0, an}, 8'h0F);
    step();
    chk("rel2_an", {4'h0, an}, 8'h0E);
    chk("rel2_seg", seg, 8'hC0);

    // scan of 1234
    digits = 16'h1234; update_valid = 1;
    step();
    update_valid = 0;
    chk("scan_pend", {7'h0, update_pending}, 8'h1);
    wait_tick();
    chk("commit_pend", {7'h0, update_pending}, 8'h0);
    scan_chk(8'h99, 8'hB0, 8'hA4, 8'hF9);

    // tear-free update of 0042 with LZ
    repeat (3) step();
    digits = 16'h0042; lz_en = 1; update_valid = 1;
    step();
    update_valid = 0;
    chk("tf_pend", {7'h0, update_pending}, 8'h1);
    prev_p = 1;
    begin
      int i = 0;
      while (i < 64 && !frame_tick) begin
        prev_p = update_pending;
        step();
        i++;
      end
    end
    chk("tf_tick", {7'h0, frame_tick}, 8'h1);
    chk("tf_prev_pend", {7'h0, prev_p}, 8'h1);
    chk("tf_clr_pend", {7'h0, update_pending}, 8'h0);
    scan_chk(8'hA4, 8'h99, 8'hFF, 8'hFF);

    // all zero with LZ
    step(); step();
    digits = 16'h0000; update_valid = 1;
    step();
    update_valid = 0;
    wait_tick();
    scan_chk(8'hC0, 8'hFF, 8'hFF, 8'hFF);

    // bypass commit on the wrap cycle, then blink
    repeat (15) step();
    digits = 16'h0005; lz_en = 0;
    blink_mask = 4'b0001; update_valid = 1;
    chk("byp_pend0", {7'h0, update_pending}, 8'h0);
    step();
    update_valid = 0;
    chk("byp_tick", {7'h0, frame_tick}, 8'h1);
    chk("byp_pend", {7'h0, update_pending}, 8'h0);
    nlit = 0;
    for (int f = 0; f < 8; f++) begin
      step(); step();
      chk("blink_an", {4'h0, an}, 8'h0E);
      lit[f] = (seg == 8'h92);
      if (lit[f]) nlit++;
      wait_tick();
    end
    chk("blink_cnt", 8'(nlit), 8'd4);
    for (int f = 0; f < 6; f++)
      chk("blink_alt", {7'h0, lit[f]},
          {7'h0, ~lit[f+2]});

    // reset mid-frame with a pending update
    repeat (3) step();
    digits = 16'h9999; update_valid = 1;
    step();
    update_valid = 0;
    chk("mr_pend1", {7'h0, update_pending}, 8'h1);
    rst = 1;
    step();
    rst = 0;
    chk("mr_pend0", {7'h0, update_pending}, 8'h0);
    chk("mr_an", {4'h0, an}, 8'h0F);
    chk("mr_seg", seg, 8'hFF);
    step();
    chk("mr1_seg", seg, 8'hC0);
    step();
    chk("mr2_an", {4'h0, an}, 8'h0E);
    chk("mr2_seg", seg, 8'hC0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      logic [15:0] msk;
      case ($urandom_range(0, 3))
        0:       msk = 16'hFFFF;
        1:       msk = 16'h00FF;
        2:       msk = 16'h000F;
        default: msk = 16'h0000;
      endcase
      rst = ($urandom_range(0, 399) == 0);
      update_valid = ($urandom_range(0, 9) == 0);
      digits = 16'($urandom) & msk;
      dp = 4'($urandom);
      blink_mask = 4'($urandom);
      lz_en = 1'($urandom);
      step();
    end
    rst = 0; update_valid = 0;
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
